// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared constants, types and LFSR step for the ground scroller
package dino_pkg;

  localparam int GROUND_W = 320;
  localparam int LFSR_W   = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef logic [2:0] speed_t;

  // Fibonacci step: taps 16,14,13,11 map to bits 15,13,12,10 of LFSR_TAPS
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/ground_lfsr.sv
// rtl/ground_lfsr.sv - 16-bit Fibonacci LFSR with seed load and step enable
module ground_lfsr
  import dino_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/ground_scroller.sv
// rtl/ground_scroller.sv - per-frame scrolling ground bitmap with LFSR-driven gaps
// Optional per-frame speed ramp is built when GROUND_SPEEDUP_EN is defined.
module ground_scroller
  import dino_pkg::*;
#(
  parameter int                WIDTH      = GROUND_W,
  parameter speed_t            SPEED_INIT = 3'd2,
  parameter speed_t            SPEED_MAX  = 3'd6,
  parameter logic [3:0]        GAP_LEN    = 4'd4,
  parameter logic [7:0]        GAP_PROB   = 8'd6,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = DEFAULT_SEED
`ifdef GROUND_SPEEDUP_EN
  ,
  parameter logic [15:0]       SPEEDUP_FRAMES = 16'd600
`endif
) (
  input  logic             vga_clk,
  input  logic             clrn,
  input  logic             frame_start,
  input  logic             run,
  input  logic             restart,
  output logic [WIDTH-1:0] px_ground,
  output speed_t           scroll_speed,
  output logic [15:0]      distance,
  output logic             busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam speed_t     SPEED_START = (SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT;

  logic [0:0]        state_q, state_d;
  speed_t            rem_q, rem_d;
  logic [WIDTH-1:0]  px_q, px_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [15:0]       dist_q, dist_d;
  logic [LFSR_W-1:0] lfsr;
  speed_t            speed_cur;
  logic              start_frame;
  logic              shift_en;
  logic              gap_hit;
  logic              new_bit;

  assign start_frame = (state_q == ST_IDLE) && frame_start && run;
  assign shift_en    = (state_q == ST_SHIFT);
  assign gap_hit     = (lfsr & 16'h00FF) < {8'd0, GAP_PROB};
  assign new_bit     = (gap_cnt_q == 4'd0) && !gap_hit;

  ground_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .load    (restart),
    .en      (shift_en),
    .lfsr    (lfsr)
  );

`ifdef GROUND_SPEEDUP_EN
  speed_t      speed_q, speed_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign speed_cur = speed_q;

  // The speed bump lands on the entry edge, after rem has latched the old speed
  always_comb begin
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    if (restart) begin
      speed_d     = SPEED_START;
      frame_cnt_d = '0;
    end else if (start_frame) begin
      if (frame_cnt_q + 16'd1 == SPEEDUP_FRAMES) begin
        frame_cnt_d = '0;
        speed_d     = (speed_q >= SPEED_MAX) ? SPEED_MAX : speed_q + 3'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      speed_q     <= SPEED_START;
      frame_cnt_q <= '0;
    end else begin
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  assign speed_cur = SPEED_START;
`endif

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    px_d      = px_q;
    gap_cnt_d = gap_cnt_q;
    dist_d    = dist_q;
    if (restart) begin
      state_d   = ST_IDLE;
      rem_d     = '0;
      px_d      = '1;
      gap_cnt_d = '0;
      dist_d    = '0;
    end else if (start_frame) begin
      state_d = ST_SHIFT;
      rem_d   = speed_cur;
    end else if (shift_en) begin
      px_d = {new_bit, px_q[WIDTH-1:1]};
      if (gap_cnt_q != 4'd0) begin
        gap_cnt_d = gap_cnt_q - 4'd1;
      end else if (gap_hit) begin
        gap_cnt_d = GAP_LEN - 4'd1;
      end
      if (dist_q != 16'hFFFF) begin
        dist_d = dist_q + 16'd1;
      end
      rem_d = rem_q - 3'd1;
      if (rem_q == 3'd1) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      px_q      <= '1;
      gap_cnt_q <= '0;
      dist_q    <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      px_q      <= px_d;
      gap_cnt_q <= gap_cnt_d;
      dist_q    <= dist_d;
    end
  end

  assign px_ground    = px_q;
  assign scroll_speed = speed_cur;
  assign distance     = dist_q;
  assign busy         = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_ground_scroller.sv
// tb/tb_ground_scroller.sv - self-checking bench for ground_scroller
module tb_ground_scroller;

  logic         vga_clk = 1'b0;
  logic         clrn = 1'b0;
  logic         frame_start = 1'b0;
  logic         run = 1'b0;
  logic         restart = 1'b0;
  logic [319:0] px_ground;
  logic [2:0]   scroll_speed;
  logic [15:0]  distance;
  logic         busy;

  logic [319:0] s_px;
  logic [2:0]   s_speed;
  logic [15:0]  s_dist;
  logic         s_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

`ifdef GROUND_SPEEDUP_EN
  localparam logic [2:0] SPD_AT_600 = 3'd3;
  localparam logic [2:0] SPD_END    = 3'd6;
  localparam int         END_FRAMES = 2500;
`else
  localparam logic [2:0] SPD_AT_600 = 3'd2;
  localparam logic [2:0] SPD_END    = 3'd2;
  localparam int         END_FRAMES = 1200;
`endif

  ground_scroller dut (
    .vga_clk      (vga_clk),
    .clrn         (clrn),
    .frame_start  (frame_start),
    .run          (run),
    .restart      (restart),
    .px_ground    (px_ground),
    .scroll_speed (scroll_speed),
    .distance     (distance),
    .busy         (busy)
  );

  // Free-running instance at top speed, used only to reach distance saturation
  ground_scroller #(.SPEED_INIT(3'd6), .SPEED_MAX(3'd6)) sat (
    .vga_clk      (vga_clk),
    .clrn         (clrn),
    .frame_start  (1'b1),
    .run          (1'b1),
    .restart      (1'b0),
    .px_ground    (s_px),
    .scroll_speed (s_speed),
    .distance     (s_dist),
    .busy         (s_busy)
  );

  always #20 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc_n <= cyc_n + 1;

  // Reference model: ground as a queue of pixels, index 0 = leftmost column
  bit m_px[$];
  int m_lfsr, m_gap, m_speed, m_dist, m_fcnt, m_total, m_busy_left;

  function automatic void m_reset();
    m_px.delete();
    for (int i = 0; i < 320; i++) m_px.push_back(1'b1);
    m_lfsr = 'hACE1;
    m_gap = 0;
    m_speed = 2;
    m_dist = 0;
    m_fcnt = 0;
    m_total = 0;
    m_busy_left = 0;
  endfunction

  function automatic void m_shift();
    bit nb;
    int fb;
    if (m_gap > 0) begin
      nb = 1'b0;
      m_gap--;
    end else if ((m_lfsr % 256) < 6) begin
      nb = 1'b0;
      m_gap = 3;
    end else begin
      nb = 1'b1;
    end
    void'(m_px.pop_front());
    m_px.push_back(nb);
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = (m_lfsr * 2 + fb) % 65536;
    if (m_dist < 65535) m_dist++;
  endfunction

  function automatic void m_frame();
    int n;
    n = m_speed;
    m_total++;
`ifdef GROUND_SPEEDUP_EN
    m_fcnt++;
    if (m_fcnt == 600) begin
      m_fcnt = 0;
      if (m_speed < 6) m_speed++;
    end
`endif
    for (int i = 0; i < n; i++) m_shift();
    m_busy_left = n;
  endfunction

  function automatic logic [319:0] m_vec();
    logic [319:0] v;
    for (int i = 0; i < 320; i++) v[i] = m_px[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance, update the model, compare
  task automatic cyc(input logic fs, input logic rn, input logic rs);
    frame_start = fs;
    run = rn;
    restart = rs;
    @(posedge vga_clk);
    #1;
    if (rs) m_reset();
    else if (m_busy_left > 0) m_busy_left--;
    else if (fs && rn) m_frame();
    check("busy", {319'd0, busy}, (m_busy_left > 0) ? 320'd1 : 320'd0);
    check("scroll_speed", {317'd0, scroll_speed}, m_speed);
    if (m_busy_left == 0) begin
      check("distance", {304'd0, distance}, m_dist);
      check("px_ground", px_ground, m_vec());
    end
  endtask

  typedef struct {
    logic        fs;
    logic        rn;
    logic        rs;
    logic        exp_busy;
    logic [15:0] exp_dist;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd3};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd4};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd4};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd4};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0};

    m_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset_px", px_ground, {320{1'b1}});
    check("reset_speed", {317'd0, scroll_speed}, 320'd2);
    check("reset_distance", {304'd0, distance}, 320'd0);
    check("reset_busy", {319'd0, busy}, 320'd0);
    clrn = 1'b1;

    // First frame from reset: two shifts, seed ACE1 feeds two 1s
    cyc(1'b1, 1'b1, 1'b0);
    check("first_busy_n1", {319'd0, busy}, 320'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check("first_busy_n2", {319'd0, busy}, 320'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check("first_busy_n3", {319'd0, busy}, 320'd0);
    check("first_distance", {304'd0, distance}, 320'd2);
    check("first_px", px_ground, {320{1'b1}});

    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].fs, tbl[i].rn, tbl[i].rs);
      check($sformatf("tbl%0d_busy", i), {319'd0, busy}, {319'd0, tbl[i].exp_busy});
      check($sformatf("tbl%0d_distance", i), {304'd0, distance}, {304'd0, tbl[i].exp_dist});
    end

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 3) != 0, ($urandom % 8) != 0, 1'b0);
    end

    // Restart one shift into a frame, after the LFSR has wandered far from its seed
    while (m_busy_left != 0) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check("restart_px", px_ground, {320{1'b1}});
    check("restart_distance", {304'd0, distance}, 320'd0);
    check("restart_busy", {319'd0, busy}, 320'd0);
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom % 2) != 0, ($urandom % 8) != 0, 1'b0);
    end

    cyc(1'b0, 1'b1, 1'b1);
    while (m_total < 599) cyc(1'b1, 1'b1, 1'b0);
    check("speed_at_599", {317'd0, scroll_speed}, 320'd2);
    while (m_total < 600) cyc(1'b1, 1'b1, 1'b0);
    check("speed_at_600", {317'd0, scroll_speed}, {317'd0, SPD_AT_600});
    while (m_total < END_FRAMES) cyc(1'b1, 1'b1, 1'b0);
    check("speed_end", {317'd0, scroll_speed}, {317'd0, SPD_END});
    cyc(1'b0, 1'b1, 1'b0);

    while (s_dist !== 16'hFFFF && cyc_n < 90000) begin
      @(posedge vga_clk);
      #1;
    end
    check("sat_reached", {304'd0, s_dist}, {304'd0, 16'hFFFF});
    repeat (30) @(posedge vga_clk);
    #1;
    check("sat_no_wrap", {304'd0, s_dist}, {304'd0, 16'hFFFF});
    check("sat_speed", {317'd0, s_speed}, 320'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
